// File: rtl/i2c_config_sequencer.sv
// i2c_config_sequencer
//
// Walks a fixed table of 24-bit codec register writes and hands them one at
// a time to an external I2C byte transmitter. Each word is loaded, issued
// with a one-cycle START_BIT once the transmitter reports ready, and then
// awaited until I2C_END (ACK/NACK via I2C_ERROR) or a timeout, which aborts
// the transfer with a one-cycle STOP_BIT. An idle gap separates words.
//
// Optional feature: define I2C_SEQ_RETRY_EN to retry a failed word up to
// MAX_RETRY times before giving up. Without it the first word error ends
// the sequence in FAIL.
//
// Ports
//   CLK_200KHZ   in   reference clock, rising edge
//   RESET_CTRL   in   synchronous active-high reset
//   GO           in   one-cycle request to start a sequence (IDLE/DONE/FAIL only)
//   I2C_READY    in   transmitter idle, may accept START_BIT
//   I2C_END      in   transmitter finished the current word (pulse)
//   I2C_ERROR    in   NACK flag, qualified by I2C_END
//   CONFIG_DATA  out  {dev addr, R/W=0, reg, data} for the transmitter
//   START_BIT    out  start pulse to the transmitter
//   STOP_BIT     out  abort pulse on timeout
//   BUSY/DONE/FAIL out sequence status
//   WORD_INDEX   out  index of the word in flight
module i2c_config_sequencer #(
    parameter int NUM_WORDS      = 11,
    parameter int GAP_CYCLES     = 20,
    parameter int TIMEOUT_CYCLES = 200,
    parameter int MAX_RETRY      = 3
) (
    input  logic        CLK_200KHZ,
    input  logic        RESET_CTRL,
    input  logic        GO,
    input  logic        I2C_READY,
    input  logic        I2C_END,
    input  logic        I2C_ERROR,
    output logic [23:0] CONFIG_DATA,
    output logic        START_BIT,
    output logic        STOP_BIT,
    output logic        BUSY,
    output logic        DONE,
    output logic        FAIL,
    output logic [3:0]  WORD_INDEX
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [3:0]    IDX_LAST = 4'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT_RDY, S_START, S_WAIT_END, S_GAP, S_DONE, S_FAIL
    } state_t;

    state_t         state_q, state_d;
    logic [23:0]    cfg_q, cfg_d;
    logic [3:0]     idx_q, idx_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic           stop_d;
    logic           word_err;
    logic           retry_pend;

`ifdef I2C_SEQ_RETRY_EN
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    logic [RW-1:0]  retry_q, retry_d;
    // A non-zero retry count on entry to GAP means the same word is resent;
    // a successful word always clears it before GAP.
    assign retry_pend = (retry_q != '0);
`else
    assign retry_pend = 1'b0;
`endif

    function automatic logic [23:0] cfg_table(input logic [3:0] idx);
        case (idx)
            4'd0:    cfg_table = 24'h341E00;
            4'd1:    cfg_table = 24'h340017;
            4'd2:    cfg_table = 24'h340217;
            4'd3:    cfg_table = 24'h340479;
            4'd4:    cfg_table = 24'h340679;
            4'd5:    cfg_table = 24'h340812;
            4'd6:    cfg_table = 24'h340A00;
            4'd7:    cfg_table = 24'h340C00;
            4'd8:    cfg_table = 24'h340E01;
            4'd9:    cfg_table = 24'h341000;
            4'd10:   cfg_table = 24'h341201;
            default: cfg_table = 24'h000000;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        idx_d    = idx_q;
        tmo_d    = tmo_q;
        gap_d    = gap_q;
        stop_d   = 1'b0;
        word_err = 1'b0;
`ifdef I2C_SEQ_RETRY_EN
        retry_d  = retry_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (GO) begin
                    state_d = S_LOAD;
                    idx_d   = 4'd0;
`ifdef I2C_SEQ_RETRY_EN
                    retry_d = '0;
`endif
                end
            end
            S_LOAD: begin
                cfg_d   = cfg_table(idx_q);
                state_d = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (I2C_READY) state_d = S_START;
            end
            S_START: begin
                tmo_d   = '0;
                state_d = S_WAIT_END;
            end
            S_WAIT_END: begin
                tmo_d = tmo_q + 1'b1;
                // I2C_END wins over a timeout landing in the same cycle.
                if (I2C_END) begin
                    if (I2C_ERROR) begin
                        word_err = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = '0;
`ifdef I2C_SEQ_RETRY_EN
                        retry_d = '0;
`endif
                    end
                end else if (tmo_q == TMO_LAST) begin
                    word_err = 1'b1;
                    stop_d   = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (retry_pend) begin
                        state_d = S_LOAD;
                    end else if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_LOAD;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (word_err) begin
`ifdef I2C_SEQ_RETRY_EN
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 1'b1;
                gap_d   = '0;
                state_d = S_GAP;
            end else begin
                state_d = S_FAIL;
            end
`else
            state_d = S_FAIL;
`endif
        end
    end

    always_ff @(posedge CLK_200KHZ) begin
        if (RESET_CTRL) begin
            state_q <= S_IDLE;
            cfg_q   <= '0;
            idx_q   <= '0;
            tmo_q   <= '0;
            gap_q   <= '0;
`ifdef I2C_SEQ_RETRY_EN
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
`ifdef I2C_SEQ_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    // The transmitter shares RESET_CTRL, so an abort during reset is suppressed.
    assign STOP_BIT    = stop_d & ~RESET_CTRL;
    assign START_BIT   = (state_q == S_START);
    assign DONE        = (state_q == S_DONE);
    assign FAIL        = (state_q == S_FAIL);
    assign BUSY        = !(state_q inside {S_IDLE, S_DONE, S_FAIL});
    assign CONFIG_DATA = cfg_q;
    assign WORD_INDEX  = idx_q;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Directed bench for i2c_config_sequencer with a small transmitter model.
// Builds with or without I2C_SEQ_RETRY_EN; retry-dependent expectations
// follow the same macro.
module tb_i2c_config_sequencer;

    logic        clk = 1'b0;
    logic        rst, go, rdy, i_end, i_err;
    logic [23:0] cfg;
    logic        start_b, stop_b, busy, done, fail;
    logic [3:0]  widx;

    always #5 clk = ~clk;

    i2c_config_sequencer dut (
        .CLK_200KHZ (clk),
        .RESET_CTRL (rst),
        .GO         (go),
        .I2C_READY  (rdy),
        .I2C_END    (i_end),
        .I2C_ERROR  (i_err),
        .CONFIG_DATA(cfg),
        .START_BIT  (start_b),
        .STOP_BIT   (stop_b),
        .BUSY       (busy),
        .DONE       (done),
        .FAIL       (fail),
        .WORD_INDEX (widx)
    );

    logic [23:0] exp_tab [11] = '{24'h341E00, 24'h340017, 24'h340217, 24'h340479,
                                  24'h340679, 24'h340812, 24'h340A00, 24'h340C00,
                                  24'h340E01, 24'h341000, 24'h341201};

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transmitter model state
    int cyc = 0;
    int cnt = 0;
    int nack_word = -1, nack_left = 0, hang_word = -1;
    int start_cnt = 0, stop_cnt = 0, start_cyc = 0, stop_cyc = 0;
    int att [16];
    logic nack_now = 1'b0;
    logic [23:0] seen [$];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        i_end = 1'b0;
        i_err = 1'b0;
        forever begin
            @(negedge clk);
            i_end = 1'b0;
            i_err = 1'b0;
            if (stop_b) begin
                stop_cnt++;
                stop_cyc = cyc;
            end
            if (start_b) begin
                start_cnt++;
                start_cyc = cyc;
                seen.push_back(cfg);
                att[widx]++;
                cnt = (int'(widx) == hang_word) ? 0 : 30;
                nack_now = (int'(widx) == nack_word) && (nack_left > 0);
                if (nack_now) nack_left--;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    i_end = 1'b1;
                    i_err = nack_now;
                end
            end
        end
    end

    task automatic clear_model();
        start_cnt = 0;
        stop_cnt  = 0;
        seen.delete();
        for (int i = 0; i < 16; i++) att[i] = 0;
        nack_word = -1;
        nack_left = 0;
        hang_word = -1;
    endtask

    task automatic go_pulse();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_fin(input int budget);
        int n = 0;
        while (!(done || fail) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(done || fail)) chk("wait_fin_timeout", 0, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cfg"},   cfg,     0);
        chk({tag, "_idx"},   widx,    0);
        chk({tag, "_start"}, start_b, 0);
        chk({tag, "_stop"},  stop_b,  0);
        chk({tag, "_busy"},  busy,    0);
        chk({tag, "_done"},  done,    0);
        chk({tag, "_fail"},  fail,    0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        go  = 1'b0;
        rdy = 1'b1;
        clear_model();
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        rst = 1'b0;

        // Full sequence, all ACK; stray GO while busy must be ignored.
        go_pulse();
        chk("A_busy", busy, 1);
        repeat (100) @(negedge clk);
        go_pulse();
        chk("A_stray_go_busy", busy, 1);
        chk("A_stray_go_idx", widx, 1);
        wait_fin(2000);
        chk("A_starts", start_cnt, 11);
        for (int i = 0; i < 11; i++)
            chk($sformatf("A_cfg%0d", i), (i < seen.size()) ? seen[i] : 24'hx, exp_tab[i]);
        chk("A_done", done, 1);
        chk("A_fail", fail, 0);
        chk("A_busy_end", busy, 0);
        chk("A_idx_end", widx, 10);
        chk("A_stops", stop_cnt, 0);

        // GO from DONE with READY held low: wait for ready, then start next cycle.
        clear_model();
        rdy = 1'b0;
        go_pulse();
        chk("B_done_cleared", done, 0);
        chk("B_busy", busy, 1);
        repeat (50) @(negedge clk);
        chk("B_no_start", start_cnt, 0);
        chk("B_cfg_loaded", cfg, 24'h341E00);
        rdy = 1'b1;
        @(negedge clk);
        chk("B_start_next", start_b, 1);
        wait_fin(2000);
        chk("B_starts", start_cnt, 11);
        chk("B_done", done, 1);

        // NACK on word 3 twice.
        clear_model();
        nack_word = 3;
        nack_left = 2;
        go_pulse();
        wait_fin(3000);
`ifdef I2C_SEQ_RETRY_EN
        chk("C_att3", att[3], 3);
        chk("C_starts", start_cnt, 13);
        chk("C_done", done, 1);
        chk("C_fail", fail, 0);
`else
        chk("C_att3", att[3], 1);
        chk("C_starts", start_cnt, 4);
        chk("C_fail", fail, 1);
        chk("C_idx", widx, 3);
`endif
        chk("C_stops", stop_cnt, 0);

        // Word 5 never ends: timeout abort.
        clear_model();
        hang_word = 5;
        go_pulse();
        wait_fin(3000);
`ifdef I2C_SEQ_RETRY_EN
        chk("D_att5", att[5], 4);
        chk("D_stops", stop_cnt, 4);
`else
        chk("D_att5", att[5], 1);
        chk("D_stops", stop_cnt, 1);
`endif
        chk("D_stop_delay", stop_cyc - start_cyc, 200);
        chk("D_fail", fail, 1);
        chk("D_done", done, 0);
        chk("D_idx", widx, 5);

        // Reset during word 7 WAIT_END, then restart from FAIL-free IDLE.
        clear_model();
        hang_word = 7;
        go_pulse();
        chk("E_fail_cleared", fail, 0);
        n = 0;
        while (start_cnt < 8 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (start_cnt < 8) chk("E_wait_word7", start_cnt, 8);
        repeat (5) @(negedge clk);
        chk("E_idx7", widx, 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("E_rst");
        repeat (3) @(negedge clk);
        chk("E_stops", stop_cnt, 0);
        clear_model();
        go_pulse();
        wait_fin(2000);
        chk("E_starts", start_cnt, 11);
        chk("E_first_cfg", (seen.size() > 0) ? seen[0] : 24'hx, 24'h341E00);
        chk("E_done", done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_config_sequencer.md
I2C_CONFIG_SEQUENCER -- requirements
Module: i2c_config_sequencer

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 11, meaning number of table words sent per sequence (1..16).
REQ-002 SHALL have parameter GAP_CYCLES, default 20, meaning idle clocks between successive words (>=1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 200, meaning max clocks from START_BIT to I2C_END before abort.
REQ-004 SHALL have parameter MAX_RETRY, default 3, meaning retries per word after the first attempt.
REQ-005 SHALL have port CLK_200KHZ  in  1  single reference clock; all logic on rising edge.
REQ-006 SHALL have port RESET_CTRL  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port GO  in  1  one-cycle request to run the configuration sequence.
REQ-008 SHALL have port I2C_READY  in  1  transmitter idle and able to accept START_BIT.
REQ-009 SHALL have port I2C_END  in  1  transmitter finished current word (one-cycle pulse).
REQ-010 SHALL have port I2C_ERROR  in  1  transmitter NACK flag, valid in the I2C_END cycle.
REQ-011 SHALL have port CONFIG_DATA  out  24  {dev addr[6:0], R/W=0, reg byte, data byte} for the transmitter.
REQ-012 SHALL have port START_BIT / STOP_BIT  out  1 each  transmitter start pulse / abort pulse.
REQ-013 SHALL have port BUSY, DONE, FAIL  out  1 each  sequence active / completed OK / completed with failure.
REQ-014 SHALL have port WORD_INDEX  out  4  index of word currently being sent.

Function
REQ-015 SHALL hold an internal table, index 0..10 = 24'h341E00, 340017, 340217, 340479, 340679, 340812, 340A00, 340C00, 340E01, 341000, 341201; indices >=11 return 24'h000000.
REQ-016 SHALL implement states IDLE, LOAD, WAIT_RDY, START, WAIT_END, GAP, DONE, FAIL.
REQ-017 SHALL in IDLE, DONE or FAIL with GO=1 go to LOAD, clear index, retry count, DONE and FAIL; GO in other states is ignored.
REQ-018 SHALL in LOAD register CONFIG_DATA = table[WORD_INDEX], then WAIT_RDY; CONFIG_DATA stays stable until the next LOAD.
REQ-019 SHALL in WAIT_RDY go to START on first cycle I2C_READY=1.
REQ-020 SHALL in START drive START_BIT=1 for exactly one cycle, clear timeout counter, go to WAIT_END.
REQ-021 SHALL in WAIT_END on I2C_END=1 with I2C_ERROR=0 go to GAP with retry count cleared.
REQ-022 SHALL in WAIT_END treat I2C_END=1 with I2C_ERROR=1, or timeout counter reaching TIMEOUT_CYCLES-1 without I2C_END, as a word error; I2C_END in the timeout cycle takes priority.
REQ-023 SHALL on timeout drive STOP_BIT=1 for exactly one cycle in the transition cycle.
REQ-024 SHALL in GAP count GAP_CYCLES clocks; then if WORD_INDEX==NUM_WORDS-1 go to DONE, else increment WORD_INDEX and go to LOAD.
REQ-025 SHALL hold DONE=1 in DONE and FAIL=1 in FAIL until next GO or reset; BUSY=1 in all states except IDLE, DONE, FAIL.
REQ-026 SHALL keep START_BIT and STOP_BIT at 0 in every cycle not named in REQ-020/023/029.
REQ-027 SHALL keep WORD_INDEX at the failing word's index in FAIL.

Reset
REQ-028 SHALL on RESET_CTRL=1 at a clock edge enter IDLE, with CONFIG_DATA=0, WORD_INDEX=0, all 1-bit outputs 0, all counters 0, regardless of state.
REQ-029 SHALL, if reset is sampled in WAIT_END, not issue STOP_BIT; transmitter is reset by the same RESET_CTRL.

Configuration
REQ-030 SHALL, with macro I2C_SEQ_RETRY_EN defined, on word error with retry count < MAX_RETRY increment retry count and go to GAP then LOAD of the same index; at MAX_RETRY go to FAIL.
REQ-031 SHALL, without I2C_SEQ_RETRY_EN, go to FAIL on the first word error; retry counter not implemented.

Verification
REQ-032 SHALL cover: GO, transmitter model always ACKs, END 30 clocks after START -> 11 START_BIT pulses, CONFIG_DATA 341E00..341201 in order, DONE=1, FAIL=0.
REQ-033 SHALL cover: I2C_READY held low 50 clocks after LOAD -> no START_BIT until READY rises, START_BIT the next cycle.
REQ-034 SHALL cover: RETRY_EN on, NACK on word 3 twice then ACK -> word 3 sent 3 times, sequence reaches DONE.
REQ-035 SHALL cover: RETRY_EN on, word 5 never ends -> STOP_BIT after 200 clocks, 4 attempts total, FAIL=1, WORD_INDEX=5; RETRY_EN off -> FAIL after first timeout.
REQ-036 SHALL cover: RESET_CTRL during word 7 WAIT_END -> next cycle IDLE, all outputs 0; subsequent GO restarts at index 0.
REQ-037 SHALL cover: GO pulsed while BUSY -> ignored, sequence unaffected; GO in DONE -> DONE cleared, new sequence.
